// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the SIMON 128/128 engine.
package simon_pkg;

  localparam int unsigned SIMON_WORD   = 64;
  localparam int unsigned SIMON_ROUNDS = 68;
  localparam int unsigned SIMON_ZLEN   = 62;

  // Key-schedule constant: ~0 ^ 3, i.e. all ones except the two LSBs.
  localparam logic [SIMON_WORD-1:0] SIMON_C = 64'hFFFF_FFFF_FFFF_FFFC;

  // z2 sequence written in reading order: the leftmost digit (MSB) is index 0.
  localparam logic [SIMON_ZLEN-1:0] SIMON_Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } simon_state_t;

  // Circular rotate left of a 64-bit word by a constant amount (1..63).
  function automatic logic [SIMON_WORD-1:0] rol64(input logic [SIMON_WORD-1:0] v,
                                                  input int unsigned n);
    return (v << n) | (v >> (SIMON_WORD - n));
  endfunction

  // Circular rotate right of a 64-bit word by a constant amount (1..63).
  function automatic logic [SIMON_WORD-1:0] ror64(input logic [SIMON_WORD-1:0] v,
                                                  input int unsigned n);
    return (v >> n) | (v << (SIMON_WORD - n));
  endfunction

  // Element zp of z2; the constant is stored MSB-first so index maps to ZLEN-1-zp.
  function automatic logic z2_bit(input logic [5:0] zp);
    logic [5:0] idx;
    idx = 6'(SIMON_ZLEN - 1) - zp;
    return SIMON_Z2[idx];
  endfunction

endpackage

// File: rtl/simon_round.sv
// One SIMON 128/128 round plus the matching m=2 key-schedule step.
// Purely combinational; chained UNROLL times by simon128_core.
module simon_round
  import simon_pkg::*;
(
  input  logic [SIMON_WORD-1:0] x_i,
  input  logic [SIMON_WORD-1:0] y_i,
  input  logic [SIMON_WORD-1:0] ka_i,
  input  logic [SIMON_WORD-1:0] kb_i,
  input  logic [5:0]            zp_i,
  output logic [SIMON_WORD-1:0] x_o,
  output logic [SIMON_WORD-1:0] y_o,
  output logic [SIMON_WORD-1:0] ka_o,
  output logic [SIMON_WORD-1:0] kb_o,
  output logic [5:0]            zp_o
);

  logic [SIMON_WORD-1:0] f_x;
  logic [SIMON_WORD-1:0] t_k;
  logic [SIMON_WORD-1:0] k_new;

  // Round function and key step; ka is the round key used by this round.
  always_comb begin
    f_x   = (rol64(x_i, 1) & rol64(x_i, 8)) ^ rol64(x_i, 2);
    x_o   = y_i ^ f_x ^ ka_i;
    y_o   = x_i;

    t_k   = ror64(kb_i, 3) ^ ror64(kb_i, 4);
    k_new = SIMON_C ^ {{(SIMON_WORD-1){1'b0}}, z2_bit(zp_i)} ^ ka_i ^ t_k;
    ka_o  = kb_i;
    kb_o  = k_new;

    // Wrap is local to each stage so it stays correct mid-chain.
    zp_o  = (zp_i == 6'(SIMON_ZLEN - 1)) ? 6'd0 : zp_i + 6'd1;
  end

endmodule

// File: rtl/simon128_core.sv
// Iterative SIMON 128/128 encryption engine with on-the-fly key expansion.
// UNROLL rounds are evaluated per clock by a chain of simon_round stages.
module simon128_core
  import simon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] ciphertext_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $fatal(1, "simon128_core: UNROLL must be 1, 2 or 4");
  end

  localparam int unsigned CntW = $clog2(SIMON_ROUNDS + 1);
  localparam logic [CntW-1:0] CntStep = CntW'(UNROLL);
  localparam logic [CntW-1:0] CntLast = CntW'(SIMON_ROUNDS);

  simon_state_t state_q, state_d;

  logic [SIMON_WORD-1:0] x_q, x_d;
  logic [SIMON_WORD-1:0] y_q, y_d;
  logic [SIMON_WORD-1:0] ka_q, ka_d;
  logic [SIMON_WORD-1:0] kb_q, kb_d;
  logic [5:0]            zp_q, zp_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [127:0]          ct_q, ct_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  // Round chain taps; index 0 is the register state, index UNROLL the next state.
  logic [SIMON_WORD-1:0] cx  [UNROLL+1];
  logic [SIMON_WORD-1:0] cy  [UNROLL+1];
  logic [SIMON_WORD-1:0] cka [UNROLL+1];
  logic [SIMON_WORD-1:0] ckb [UNROLL+1];
  logic [5:0]            czp [UNROLL+1];

  assign cx[0]  = x_q;
  assign cy[0]  = y_q;
  assign cka[0] = ka_q;
  assign ckb[0] = kb_q;
  assign czp[0] = zp_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    simon_round u_round (
      .x_i  (cx[i]),
      .y_i  (cy[i]),
      .ka_i (cka[i]),
      .kb_i (ckb[i]),
      .zp_i (czp[i]),
      .x_o  (cx[i+1]),
      .y_o  (cy[i+1]),
      .ka_o (cka[i+1]),
      .kb_o (ckb[i+1]),
      .zp_o (czp[i+1])
    );
  end

  // Next-state logic: accept starts in IDLE/DONE, advance the chain in RUN.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    zp_d    = zp_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          x_d     = plaintext_i[127:64];
          y_d     = plaintext_i[63:0];
          ka_d    = key_i[63:0];
          kb_d    = key_i[127:64];
          zp_d    = 6'd0;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // start_i is deliberately not looked at here.
        x_d   = cx[UNROLL];
        y_d   = cy[UNROLL];
        ka_d  = cka[UNROLL];
        kb_d  = ckb[UNROLL];
        zp_d  = czp[UNROLL];
        cnt_d = cnt_q + CntStep;
        if (cnt_d == CntLast) begin
          ct_d    = {cx[UNROLL], cy[UNROLL]};
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over start_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      zp_q    <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      zp_q    <= zp_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign valid_o      = valid_q;
  assign ciphertext_o = ct_q;

endmodule

// File: tb/tb_simon128_core.sv
// Self-checking bench for simon128_core: three instances (UNROLL 1, 2, 4) share stimulus.
module tb_simon128_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] pt;
  logic [127:0] key;
  logic [2:0]   busy_w;
  logic [2:0]   valid_w;
  logic [127:0] ct_w [3];

  int tests = 0;
  int fails = 0;

  localparam int UN [3] = '{1, 2, 4};
  localparam logic [127:0] PubKey = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PubPt  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] PubCt  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] B2b    = 128'h74636364616e69656c31322f32303234;
  localparam logic [127:0] AltV   = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  always #5 clk = ~clk;

  simon128_core #(.UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .plaintext_i(pt), .key_i(key),
    .busy_o(busy_w[0]), .valid_o(valid_w[0]), .ciphertext_o(ct_w[0])
  );
  simon128_core #(.UNROLL(2)) u2 (
    .clk(clk), .rst(rst), .start_i(start), .plaintext_i(pt), .key_i(key),
    .busy_o(busy_w[1]), .valid_o(valid_w[1]), .ciphertext_o(ct_w[1])
  );
  simon128_core #(.UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .start_i(start), .plaintext_i(pt), .key_i(key),
    .busy_o(busy_w[2]), .valid_o(valid_w[2]), .ciphertext_o(ct_w[2])
  );

  // busy and valid must never be high together on any instance.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      assert (!(busy_w[j] && valid_w[j]))
      else begin
        fails++;
        $display("FAIL busy_valid_excl[u%0d]: busy=%0b valid=%0b required not both 1",
                 UN[j], busy_w[j], valid_w[j]);
      end
    end
  end

  // Behavioural SIMON 128/128 reference: full key schedule first, then 68 rounds.
  function automatic logic [63:0] rl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] simon_ref(input logic [127:0] p, input logic [127:0] k);
    string zs = "10101111011100000011010010011000101000010001111110010110110011";
    logic [63:0] rk [68];
    logic [63:0] x, y, t;
    rk[0] = k[63:0];
    rk[1] = k[127:64];
    for (int i = 0; i < 66; i++) begin
      t = {rk[i+1][2:0], rk[i+1][63:3]};
      t = t ^ {t[0], t[63:1]};
      rk[i+2] = ~rk[i] ^ t ^ 64'd3 ^ 64'(zs[i % 62] == "1");
    end
    x = p[127:64];
    y = p[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && busy_w != 3'b000; n++) step();
    chk("wait_idle", 128'(busy_w), 128'd0);
  endtask

  // Start all three instances on one vector and check latency and result of each.
  task automatic run_vec(input string name, input logic [127:0] p, input logic [127:0] k,
                         input logic [127:0] exp);
    logic [2:0]   got;
    int           lat [3];
    logic [127:0] res [3];
    wait_idle();
    start = 1'b1;
    pt    = p;
    key   = k;
    step();
    start = 1'b0;
    chk({name, "_busy0"}, 128'(busy_w), 128'd7);
    chk({name, "_valid0"}, 128'(valid_w), 128'd0);
    got = 3'b000;
    for (int j = 0; j < 3; j++) begin
      lat[j] = -1;
      res[j] = '0;
    end
    for (int cyc = 1; cyc <= 100 && got != 3'b111; cyc++) begin
      step();
      for (int j = 0; j < 3; j++) begin
        if (!got[j] && valid_w[j]) begin
          got[j] = 1'b1;
          lat[j] = cyc;
          res[j] = ct_w[j];
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_lat_u%0d", name, UN[j]), 128'(lat[j]), 128'(68 / UN[j]));
      chk($sformatf("%s_ct_u%0d", name, UN[j]), res[j], exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] p;
    logic [127:0] k;
    logic [127:0] c;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int   busy_cnt;
    int   lat;
    logic [127:0] rp, rk;

    tbl[0] = '{"pub",   PubPt,   PubKey,  PubCt};
    tbl[1] = '{"zeros", '0,      '0,      simon_ref('0, '0)};
    tbl[2] = '{"ones",  '1,      '1,      simon_ref('1, '1)};
    tbl[3] = '{"b2bv",  B2b,     B2b,     simon_ref(B2b, B2b)};

    rst   = 1'b1;
    start = 1'b0;
    pt    = '0;
    key   = '0;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst_busy_u%0d", UN[j]), 128'(busy_w[j]), 128'd0);
      chk($sformatf("rst_valid_u%0d", UN[j]), 128'(valid_w[j]), 128'd0);
      chk($sformatf("rst_ct_u%0d", UN[j]), ct_w[j], 128'd0);
    end
    rst = 1'b0;

    // Table vectors across all unroll factors.
    for (int i = 0; i < 4; i++) run_vec(tbl[i].name, tbl[i].p, tbl[i].k, tbl[i].c);

    // Random vectors against the reference model.
    for (int i = 0; i < 6; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_vec($sformatf("rand%0d", i), rp, rk, simon_ref(rp, rk));
    end

    // Start pulse at cycle 20 while u1 is running must be ignored.
    wait_idle();
    start = 1'b1;
    pt    = PubPt;
    key   = PubKey;
    step();
    start    = 1'b0;
    busy_cnt = 0;
    lat      = -1;
    for (int c = 1; c <= 100; c++) begin
      if (c == 20) begin
        start = 1'b1;
        pt    = AltV;
        key   = ~AltV;
      end
      step();
      start = 1'b0;
      if (busy_w[0]) busy_cnt++;
      if (valid_w[0]) begin
        lat = c;
        break;
      end
    end
    chk("ignore_lat", 128'(lat), 128'd68);
    chk("ignore_busy_cycles", 128'(busy_cnt), 128'd67);
    chk("ignore_ct", ct_w[0], PubCt);
    chk("ignore_busy_end", 128'(busy_w[0]), 128'd0);

    // Back-to-back: start on the first cycle valid is seen.
    start = 1'b1;
    pt    = B2b;
    key   = B2b;
    step();
    start = 1'b0;
    chk("b2b_valid_drop", 128'(valid_w[0]), 128'd0);
    chk("b2b_busy", 128'(busy_w[0]), 128'd1);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (valid_w[0]) begin
        lat = c;
        break;
      end
    end
    chk("b2b_lat", 128'(lat), 128'd68);
    chk("b2b_ct", ct_w[0], simon_ref(B2b, B2b));

    // Reset at cycle 30 aborts; start asserted on the same edge must lose.
    wait_idle();
    start = 1'b1;
    pt    = PubPt;
    key   = PubKey;
    step();
    start = 1'b0;
    for (int c = 1; c < 30; c++) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("abort_busy_u%0d", UN[j]), 128'(busy_w[j]), 128'd0);
      chk($sformatf("abort_valid_u%0d", UN[j]), 128'(valid_w[j]), 128'd0);
      chk($sformatf("abort_ct_u%0d", UN[j]), ct_w[j], 128'd0);
    end
    step();
    chk("abort_stays_idle", 128'(busy_w), 128'd0);
    run_vec("after_abort", PubPt, PubKey, PubCt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
